video_timing_pattern: RTL and testbench

Parametrised pixel-clock video timing and test-pattern generator, the successor to the fixed 1280x720 test-picture source that feeds `vga2dvid`. Any CEA/VESA-style mode is set through generics, with programmable sync polarity and colour depth. Four test patterns are selectable at run time, and a new selection takes effect only at a frame boundary. All outputs are registered and mutually aligned, so the block drops directly in front of the TMDS encoder.

---
 rtl/video_timing_pattern.sv | 192 +++++++++++++++++++
 tb/tb_video_timing_pattern.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_pattern.sv
// Free-running pixel-clock video timing generator with four run-time selectable
// test patterns; every output is registered and aligned to the same pixel.
module video_timing_pattern #(
   parameter int C_resolution_x      = 1280,
   parameter int C_hsync_front_porch = 110,
   parameter int C_hsync_pulse       = 40,
   parameter int C_hsync_back_porch  = 220,
   parameter int C_resolution_y      = 720,
   parameter int C_vsync_front_porch = 5,
   parameter int C_vsync_pulse       = 5,
   parameter int C_vsync_back_porch  = 20,
   parameter int C_hsync_polarity    = 1,
   parameter int C_vsync_polarity    = 1,
   parameter int C_bits              = 8,
   localparam int H_TOTAL = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch,
   localparam int V_TOTAL = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL)
) (
   input  logic                clk_pixel,
   input  logic                rst_n,
   input  logic [1:0]          pattern_sel,
   input  logic [3*C_bits-1:0] solid_rgb,
   output logic [C_bits-1:0]   vga_r,
   output logic [C_bits-1:0]   vga_g,
   output logic [C_bits-1:0]   vga_b,
   output logic                vga_hsync,
   output logic                vga_vsync,
   output logic                vga_blank,
   output logic [HW-1:0]       beam_x,
   output logic [VW-1:0]       beam_y,
   output logic                frame_start
);

   localparam logic [HW-1:0] H_ACT      = HW'(C_resolution_x);
   localparam logic [HW-1:0] H_EDGE     = HW'(C_resolution_x - 1);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(C_resolution_x + C_hsync_front_porch);
   localparam logic [HW-1:0] H_SYNC_END = HW'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] BAR_W      = HW'(C_resolution_x / 8);
   localparam logic [VW-1:0] V_ACT      = VW'(C_resolution_y);
   localparam logic [VW-1:0] V_EDGE     = VW'(C_resolution_y - 1);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(C_resolution_y + C_vsync_front_porch);
   localparam logic [VW-1:0] V_SYNC_END = VW'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic          HPOL       = (C_hsync_polarity != 0);
   localparam logic          VPOL       = (C_vsync_polarity != 0);
   localparam logic [C_bits-1:0] FULL   = {C_bits{1'b1}};
   localparam logic [C_bits-1:0] ZERO   = {C_bits{1'b0}};

   logic [HW-1:0]     hc_r;
   logic [VW-1:0]     vc_r;
   logic [1:0]        pat_r;
   logic [HW-1:0]     hc_nxt_s;
   logic [VW-1:0]     vc_nxt_s;
   logic              origin_s;
   logic [1:0]        pat_s;
   logic              blank_s;
   logic              hs_act_s;
   logic              vs_act_s;
   logic [HW-1:0]     bar_idx_s;
   logic [2:0]        bar_s;
   logic [2:0]        bar_rgb_s;
   logic              grid_s;
   logic [C_bits-1:0] pr_s, pg_s, pb_s;
   logic [C_bits-1:0] r_s, g_s, b_s;

   // Beam counter next state: hc wraps at the line end and carries into vc
   always_comb begin
      hc_nxt_s = hc_r + HW'(1);
      vc_nxt_s = vc_r;
      if (hc_r == H_LAST) begin
         hc_nxt_s = HW'(0);
         if (vc_r == V_LAST) begin
            vc_nxt_s = VW'(0);
         end else begin
            vc_nxt_s = vc_r + VW'(1);
         end
      end else begin
         vc_nxt_s = vc_r;
      end
   end

   // Region decode and pattern selection; the selection is only taken at pixel (0,0)
   always_comb begin
      origin_s  = (hc_r == HW'(0)) && (vc_r == VW'(0));
      pat_s     = origin_s ? pattern_sel : pat_r;
      blank_s   = !((hc_r < H_ACT) && (vc_r < V_ACT));
      hs_act_s  = (hc_r >= H_SYNC_BEG) && (hc_r < H_SYNC_END);
      vs_act_s  = (vc_r >= V_SYNC_BEG) && (vc_r < V_SYNC_END);
      bar_idx_s = hc_r / BAR_W;
      bar_s     = (bar_idx_s > HW'(7)) ? 3'd7 : bar_idx_s[2:0];
      grid_s    = (5'(hc_r) == 5'd0) || (5'(vc_r) == 5'd0) || (hc_r == H_EDGE) || (vc_r == V_EDGE);
   end

   // Bar colour table, {r,g,b} on/off per bar index
   always_comb begin
      bar_rgb_s = 3'b000;
      case (bar_s)
         3'd0:    bar_rgb_s = 3'b111;
         3'd1:    bar_rgb_s = 3'b110;
         3'd2:    bar_rgb_s = 3'b011;
         3'd3:    bar_rgb_s = 3'b010;
         3'd4:    bar_rgb_s = 3'b101;
         3'd5:    bar_rgb_s = 3'b100;
         3'd6:    bar_rgb_s = 3'b001;
         default: bar_rgb_s = 3'b000;
      endcase
   end

   // Pattern colour generation followed by blanking
   always_comb begin
      pr_s = ZERO;
      pg_s = ZERO;
      pb_s = ZERO;
      case (pat_s)
         2'd0: begin
            pr_s = bar_rgb_s[2] ? FULL : ZERO;
            pg_s = bar_rgb_s[1] ? FULL : ZERO;
            pb_s = bar_rgb_s[0] ? FULL : ZERO;
         end
         2'd1: begin
            pr_s = C_bits'(hc_r);
            pg_s = C_bits'(vc_r);
            pb_s = C_bits'(hc_r) + C_bits'(vc_r);
         end
         2'd2: begin
            pr_s = grid_s ? FULL : ZERO;
            pg_s = grid_s ? FULL : ZERO;
            pb_s = grid_s ? FULL : ZERO;
         end
         2'd3: begin
            pr_s = solid_rgb[3*C_bits-1:2*C_bits];
            pg_s = solid_rgb[2*C_bits-1:C_bits];
            pb_s = solid_rgb[C_bits-1:0];
         end
         default: begin
            pr_s = ZERO;
            pg_s = ZERO;
            pb_s = ZERO;
         end
      endcase
      if (blank_s) begin
         r_s = ZERO;
         g_s = ZERO;
         b_s = ZERO;
      end else begin
         r_s = pr_s;
         g_s = pg_s;
         b_s = pb_s;
      end
   end

   // Beam counters and latched pattern
   always_ff @(posedge clk_pixel) begin
      if (!rst_n) begin
         hc_r  <= HW'(0);
         vc_r  <= VW'(0);
         pat_r <= 2'd0;
      end else begin
         hc_r  <= hc_nxt_s;
         vc_r  <= vc_nxt_s;
         pat_r <= pat_s;
      end
   end

   // Output register stage, one pixel behind the counters
   always_ff @(posedge clk_pixel) begin
      if (!rst_n) begin
         vga_r       <= ZERO;
         vga_g       <= ZERO;
         vga_b       <= ZERO;
         vga_hsync   <= !HPOL;
         vga_vsync   <= !VPOL;
         vga_blank   <= 1'b1;
         beam_x      <= HW'(0);
         beam_y      <= VW'(0);
         frame_start <= 1'b0;
      end else begin
         vga_r       <= r_s;
         vga_g       <= g_s;
         vga_b       <= b_s;
         vga_hsync   <= hs_act_s ? HPOL : !HPOL;
         vga_vsync   <= vs_act_s ? VPOL : !VPOL;
         vga_blank   <= blank_s;
         beam_x      <= hc_r;
         beam_y      <= vc_r;
         frame_start <= origin_s;
      end
   end

endmodule

// File: tb/tb_video_timing_pattern.sv
// Scoreboard bench: two instances (16x4/8-bit/positive sync and 20x4/4-bit/negative sync)
// driven with random pattern/colour stimulus and compared against a raster-arithmetic model.
module tb_video_timing_pattern;

   typedef struct {
      int rx, ry, hfp, hp, hbp, vfp, vp, vbp, bits, hpol, vpol;
   } cfg_t;

   typedef struct packed {
      logic [9:0]  r, g, b;
      logic        hs, vs, blank;
      logic [15:0] x, y;
      logic        fs;
   } px_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  pattern_sel;
   logic [23:0] solid_a;
   logic [11:0] solid_b;

   logic [7:0]  r_a, g_a, b_a;
   logic        hs_a, vs_a, bl_a, fs_a;
   logic [4:0]  x_a;
   logic [2:0]  y_a;
   logic [3:0]  r_b, g_b, b_b;
   logic        hs_b, vs_b, bl_b, fs_b;
   logic [4:0]  x_b;
   logic [2:0]  y_b;

   video_timing_pattern #(
      .C_resolution_x(16), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(3),
      .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(1),
      .C_hsync_polarity(1), .C_vsync_polarity(1), .C_bits(8)
   ) dut_a (
      .clk_pixel(clk), .rst_n(rst_n), .pattern_sel(pattern_sel), .solid_rgb(solid_a),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hsync(hs_a), .vga_vsync(vs_a),
      .vga_blank(bl_a), .beam_x(x_a), .beam_y(y_a), .frame_start(fs_a)
   );

   video_timing_pattern #(
      .C_resolution_x(20), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(3),
      .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(1),
      .C_hsync_polarity(0), .C_vsync_polarity(0), .C_bits(4)
   ) dut_b (
      .clk_pixel(clk), .rst_n(rst_n), .pattern_sel(pattern_sel), .solid_rgb(solid_b),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hsync(hs_b), .vga_vsync(vs_b),
      .vga_blank(bl_b), .beam_x(x_b), .beam_y(y_b), .frame_start(fs_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cfg_t        cfg_a, cfg_b;
   px_t         q_a[$];
   px_t         q_b[$];
   int          k_a, pat_a, k_b, pat_b;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [1:0]  sel_v;
   logic [23:0] sa_v;
   logic [11:0] sb_v;
   logic [2:0]  bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

   function automatic px_t rst_px(cfg_t c);
      px_t e;
      e       = '0;
      e.hs    = (c.hpol == 0);
      e.vs    = (c.vpol == 0);
      e.blank = 1'b1;
      return e;
   endfunction

   // Expected output for raster position (x,y) straight from the region and pattern rules
   function automatic px_t ref_px(cfg_t c, int x, int y, int pat, logic [29:0] solid);
      px_t e;
      int  full, w, idx;
      logic [2:0] bar;
      bit  act, white;
      full    = (1 << c.bits) - 1;
      e       = '0;
      act     = (x < c.rx) && (y < c.ry);
      e.hs    = ((x >= c.rx + c.hfp) && (x < c.rx + c.hfp + c.hp)) ? (c.hpol != 0) : (c.hpol == 0);
      e.vs    = ((y >= c.ry + c.vfp) && (y < c.ry + c.vfp + c.vp)) ? (c.vpol != 0) : (c.vpol == 0);
      e.blank = !act;
      e.x     = 16'(x);
      e.y     = 16'(y);
      e.fs    = (x == 0) && (y == 0);
      if (act) begin
         case (pat)
            0: begin
               w   = c.rx / 8;
               idx = x / w;
               if (idx > 7) idx = 7;
               bar = bar_tab[idx];
               e.r = bar[2] ? 10'(full) : 10'd0;
               e.g = bar[1] ? 10'(full) : 10'd0;
               e.b = bar[0] ? 10'(full) : 10'd0;
            end
            1: begin
               e.r = 10'(x % (full + 1));
               e.g = 10'(y % (full + 1));
               e.b = 10'((x + y) % (full + 1));
            end
            2: begin
               white = (x % 32 == 0) || (y % 32 == 0) || (x == c.rx - 1) || (y == c.ry - 1);
               e.r = white ? 10'(full) : 10'd0;
               e.g = e.r;
               e.b = e.r;
            end
            default: begin
               e.r = 10'((solid >> (2 * c.bits)) & 30'(full));
               e.g = 10'((solid >> c.bits) & 30'(full));
               e.b = 10'(solid & 30'(full));
            end
         endcase
      end
      return e;
   endfunction

   // One clock edge of the model: k counts pixels since release, frame = k / total
   task automatic model_edge(input cfg_t c, input logic rst, input logic [1:0] sel,
                             input logic [29:0] solid, inout int k, inout int pat, output px_t e);
      int htot, total, p;
      htot  = c.rx + c.hfp + c.hp + c.hbp;
      total = htot * (c.ry + c.vfp + c.vp + c.vbp);
      if (!rst) begin
         e   = rst_px(c);
         k   = 0;
         pat = 0;
      end else begin
         p = k % total;
         if (p == 0) pat = int'(sel);
         e = ref_px(c, p % htot, p / htot, pat, solid);
         k = k + 1;
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] s, input logic [23:0] sa, input logic [11:0] sb);
      px_t ea, eb;
      rst_n       = r;
      pattern_sel = s;
      solid_a     = sa;
      solid_b     = sb;
      model_edge(cfg_a, r, s, 30'(sa), k_a, pat_a, ea);
      model_edge(cfg_b, r, s, 30'(sb), k_b, pat_b, eb);
      q_a.push_back(ea);
      q_b.push_back(eb);
      @(negedge clk);
   endtask

   task automatic rand_step();
      if ($urandom_range(49) == 0) sel_v = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) begin
         sa_v = 24'($urandom);
         sb_v = 12'($urandom);
      end
   endtask

   task automatic check_px(input string name, input int cyc, input px_t a, input px_t e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s cyc=%0d got rgb=%h/%h/%h hs=%b vs=%b blank=%b xy=%0d,%0d fs=%b want rgb=%h/%h/%h hs=%b vs=%b blank=%b xy=%0d,%0d fs=%b",
                  name, cyc, a.r, a.g, a.b, a.hs, a.vs, a.blank, a.x, a.y, a.fs,
                  e.r, e.g, e.b, e.hs, e.vs, e.blank, e.x, e.y, e.fs);
      end
   endtask

   // Monitor: after each edge pop the expected pixel for each instance and compare
   int cyc = 0;
   int last_fs = -1;
   bit rst_seen = 1'b1;
   always @(posedge clk) begin
      px_t ea, eb, aa, ab;
      #1;
      cyc++;
      if (q_a.size() > 0) begin
         ea = q_a.pop_front();
         aa = '{r: 10'(r_a), g: 10'(g_a), b: 10'(b_a), hs: hs_a, vs: vs_a, blank: bl_a,
                x: 16'(x_a), y: 16'(y_a), fs: fs_a};
         check_px("px_a", cyc, aa, ea);
         if (ea.blank && ea.x == 16'd0 && ea.y == 16'd0 && ea.hs == 1'b0) rst_seen = 1'b1;
      end
      if (q_b.size() > 0) begin
         eb = q_b.pop_front();
         ab = '{r: 10'(r_b), g: 10'(g_b), b: 10'(b_b), hs: hs_b, vs: vs_b, blank: bl_b,
                x: 16'(x_b), y: 16'(y_b), fs: fs_b};
         check_px("px_b", cyc, ab, eb);
      end
      if (fs_a === 1'b1) begin
         if (last_fs >= 0 && !rst_seen) begin
            n_cmp++;
            if (cyc - last_fs != 192) begin
               n_err++;
               $display("FAIL frame_period_a got %0d cycles want 192", cyc - last_fs);
            end
         end
         last_fs  = cyc;
         rst_seen = 1'b0;
      end
   end

   initial begin
      cfg_a = '{rx: 16, ry: 4, hfp: 2, hp: 3, hbp: 3, vfp: 1, vp: 2, vbp: 1, bits: 8, hpol: 1, vpol: 1};
      cfg_b = '{rx: 20, ry: 4, hfp: 2, hp: 3, hbp: 3, vfp: 1, vp: 2, vbp: 1, bits: 4, hpol: 0, vpol: 0};
      k_a = 0; pat_a = 0; k_b = 0; pat_b = 0;
      sel_v = 2'd0;
      sa_v  = 24'h123456;
      sb_v  = 12'h9a5;

      repeat (4) drive(1'b0, 2'($urandom_range(3)), 24'($urandom), 12'($urandom));
      repeat (600) begin
         rand_step();
         drive(1'b1, sel_v, sa_v, sb_v);
      end

      // Bars latched at a frame start, solid requested on line 2 of that frame
      sel_v = 2'd0;
      while (k_a % 192 != 0) drive(1'b1, sel_v, sa_v, sb_v);
      while (k_a % 192 != 48) drive(1'b1, sel_v, sa_v, sb_v);
      sel_v = 2'd3;
      sa_v  = 24'h123456;
      repeat (400) drive(1'b1, sel_v, sa_v, sb_v);

      // Reset in the middle of line 2 of instance A's frame
      while (k_a % 192 != 55) drive(1'b1, sel_v, sa_v, sb_v);
      repeat (2) drive(1'b0, sel_v, sa_v, sb_v);
      sel_v = 2'd1;
      repeat (300) drive(1'b1, sel_v, sa_v, sb_v);

      for (int i = 0; i < 4; i++) begin
         sel_v = 2'((i + 1) % 4);
         repeat (450) begin
            if ($urandom_range(15) == 0) begin
               sa_v = 24'($urandom);
               sb_v = 12'($urandom);
            end
            drive(1'b1, sel_v, sa_v, sb_v);
         end
      end

      n_cmp++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
